// File: rtl/keyboard_pkg.sv
// Shared types, prefix/special-code constants and the set-2 scancode lookup
// used by the PS/2 key decoder.
package keyboard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } prefix_state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_LETTER,
    CLS_SHIFT,
    CLS_PLAIN,
    CLS_SPECIAL,
    CLS_MOD
  } key_class_e;

  typedef struct packed {
    key_class_e cls;
    logic [6:0] code;
  } base_key_t;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;

  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  localparam logic [6:0] K_LSHIFT = 7'h01;
  localparam logic [6:0] K_RSHIFT = 7'h02;
  localparam logic [6:0] K_LCTRL  = 7'h03;
  localparam logic [6:0] K_RCTRL  = 7'h04;
  localparam logic [6:0] K_LALT   = 7'h05;
  localparam logic [6:0] K_RALT   = 7'h06;
  localparam logic [6:0] K_INS    = 7'h10;
  localparam logic [6:0] K_HOME   = 7'h11;
  localparam logic [6:0] K_PGUP   = 7'h12;
  localparam logic [6:0] K_DEL    = 7'h13;
  localparam logic [6:0] K_END    = 7'h14;
  localparam logic [6:0] K_PGDN   = 7'h15;
  localparam logic [6:0] K_UP     = 7'h21;
  localparam logic [6:0] K_LEFT   = 7'h22;
  localparam logic [6:0] K_DOWN   = 7'h23;
  localparam logic [6:0] K_RIGHT  = 7'h24;
  localparam logic [6:0] K_CAPS   = 7'h25;

  function automatic base_key_t mk(input key_class_e cls, input logic [6:0] code);
    base_key_t r;
    r.cls  = cls;
    r.code = code;
    return r;
  endfunction

  // Letters are stored lowercase; keypad keys are CLS_PLAIN so shift never alters them.
  function automatic base_key_t scan_to_base(input logic [7:0] code, input logic ext);
    base_key_t r;
    r = mk(CLS_NONE, 7'h00);
    case ({ext, code})
      9'h01C: r = mk(CLS_LETTER, 7'h61);
      9'h032: r = mk(CLS_LETTER, 7'h62);
      9'h021: r = mk(CLS_LETTER, 7'h63);
      9'h023: r = mk(CLS_LETTER, 7'h64);
      9'h024: r = mk(CLS_LETTER, 7'h65);
      9'h02B: r = mk(CLS_LETTER, 7'h66);
      9'h034: r = mk(CLS_LETTER, 7'h67);
      9'h033: r = mk(CLS_LETTER, 7'h68);
      9'h043: r = mk(CLS_LETTER, 7'h69);
      9'h03B: r = mk(CLS_LETTER, 7'h6A);
      9'h042: r = mk(CLS_LETTER, 7'h6B);
      9'h04B: r = mk(CLS_LETTER, 7'h6C);
      9'h03A: r = mk(CLS_LETTER, 7'h6D);
      9'h031: r = mk(CLS_LETTER, 7'h6E);
      9'h044: r = mk(CLS_LETTER, 7'h6F);
      9'h04D: r = mk(CLS_LETTER, 7'h70);
      9'h015: r = mk(CLS_LETTER, 7'h71);
      9'h02D: r = mk(CLS_LETTER, 7'h72);
      9'h01B: r = mk(CLS_LETTER, 7'h73);
      9'h02C: r = mk(CLS_LETTER, 7'h74);
      9'h03C: r = mk(CLS_LETTER, 7'h75);
      9'h02A: r = mk(CLS_LETTER, 7'h76);
      9'h01D: r = mk(CLS_LETTER, 7'h77);
      9'h022: r = mk(CLS_LETTER, 7'h78);
      9'h035: r = mk(CLS_LETTER, 7'h79);
      9'h01A: r = mk(CLS_LETTER, 7'h7A);
      9'h016: r = mk(CLS_SHIFT, 7'h31);
      9'h01E: r = mk(CLS_SHIFT, 7'h32);
      9'h026: r = mk(CLS_SHIFT, 7'h33);
      9'h025: r = mk(CLS_SHIFT, 7'h34);
      9'h02E: r = mk(CLS_SHIFT, 7'h35);
      9'h036: r = mk(CLS_SHIFT, 7'h36);
      9'h03D: r = mk(CLS_SHIFT, 7'h37);
      9'h03E: r = mk(CLS_SHIFT, 7'h38);
      9'h046: r = mk(CLS_SHIFT, 7'h39);
      9'h045: r = mk(CLS_SHIFT, 7'h30);
      9'h00E: r = mk(CLS_SHIFT, 7'h60);
      9'h04E: r = mk(CLS_SHIFT, 7'h2D);
      9'h055: r = mk(CLS_SHIFT, 7'h3D);
      9'h054: r = mk(CLS_SHIFT, 7'h5B);
      9'h05B: r = mk(CLS_SHIFT, 7'h5D);
      9'h05D: r = mk(CLS_SHIFT, 7'h5C);
      9'h04C: r = mk(CLS_SHIFT, 7'h3B);
      9'h052: r = mk(CLS_SHIFT, 7'h27);
      9'h041: r = mk(CLS_SHIFT, 7'h2C);
      9'h049: r = mk(CLS_SHIFT, 7'h2E);
      9'h04A: r = mk(CLS_SHIFT, 7'h2F);
      9'h029: r = mk(CLS_PLAIN, 7'h20);
      9'h00D: r = mk(CLS_PLAIN, 7'h09);
      9'h066: r = mk(CLS_PLAIN, 7'h08);
      9'h05A: r = mk(CLS_PLAIN, 7'h0D);
      9'h15A: r = mk(CLS_PLAIN, 7'h0D);
      9'h076: r = mk(CLS_PLAIN, 7'h1B);
      9'h070: r = mk(CLS_PLAIN, 7'h30);
      9'h069: r = mk(CLS_PLAIN, 7'h31);
      9'h072: r = mk(CLS_PLAIN, 7'h32);
      9'h07A: r = mk(CLS_PLAIN, 7'h33);
      9'h06B: r = mk(CLS_PLAIN, 7'h34);
      9'h073: r = mk(CLS_PLAIN, 7'h35);
      9'h074: r = mk(CLS_PLAIN, 7'h36);
      9'h06C: r = mk(CLS_PLAIN, 7'h37);
      9'h075: r = mk(CLS_PLAIN, 7'h38);
      9'h07D: r = mk(CLS_PLAIN, 7'h39);
      9'h07C: r = mk(CLS_PLAIN, 7'h2A);
      9'h07B: r = mk(CLS_PLAIN, 7'h2D);
      9'h079: r = mk(CLS_PLAIN, 7'h2B);
      9'h071: r = mk(CLS_PLAIN, 7'h7F);
      9'h14A: r = mk(CLS_PLAIN, 7'h2F);
      9'h175: r = mk(CLS_SPECIAL, K_UP);
      9'h16B: r = mk(CLS_SPECIAL, K_LEFT);
      9'h172: r = mk(CLS_SPECIAL, K_DOWN);
      9'h174: r = mk(CLS_SPECIAL, K_RIGHT);
      9'h170: r = mk(CLS_SPECIAL, K_INS);
      9'h16C: r = mk(CLS_SPECIAL, K_HOME);
      9'h17D: r = mk(CLS_SPECIAL, K_PGUP);
      9'h171: r = mk(CLS_SPECIAL, K_DEL);
      9'h169: r = mk(CLS_SPECIAL, K_END);
      9'h17A: r = mk(CLS_SPECIAL, K_PGDN);
      9'h012: r = mk(CLS_MOD, K_LSHIFT);
      9'h059: r = mk(CLS_MOD, K_RSHIFT);
      9'h014: r = mk(CLS_MOD, K_LCTRL);
      9'h114: r = mk(CLS_MOD, K_RCTRL);
      9'h011: r = mk(CLS_MOD, K_LALT);
      9'h111: r = mk(CLS_MOD, K_RALT);
      9'h058: r = mk(CLS_MOD, K_CAPS);
      default: r = mk(CLS_NONE, 7'h00);
    endcase
    return r;
  endfunction

  function automatic logic [6:0] shift_char(input logic [6:0] c);
    logic [6:0] r;
    r = c;
    case (c)
      7'h31: r = 7'h21;
      7'h32: r = 7'h40;
      7'h33: r = 7'h23;
      7'h34: r = 7'h24;
      7'h35: r = 7'h25;
      7'h36: r = 7'h5E;
      7'h37: r = 7'h26;
      7'h38: r = 7'h2A;
      7'h39: r = 7'h28;
      7'h30: r = 7'h29;
      7'h2D: r = 7'h5F;
      7'h3D: r = 7'h2B;
      7'h5B: r = 7'h7B;
      7'h5D: r = 7'h7D;
      7'h5C: r = 7'h7C;
      7'h3B: r = 7'h3A;
      7'h27: r = 7'h22;
      7'h2C: r = 7'h3C;
      7'h2E: r = 7'h3E;
      7'h2F: r = 7'h3F;
      7'h60: r = 7'h7E;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead synchronous FIFO for decoded key events; a push into a full
// FIFO succeeds only when a pop happens in the same cycle.
module key_event_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && !do_push;
  assign valid_o = !empty;
  // Zero while empty so the consumer never sees stale storage.
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: prefix tracking, modifier/CapsLock state and
// ASCII/special event generation into a valid/ready event FIFO.
module ps2_key_decoder
  import keyboard_pkg::*;
#(
  parameter int KEY_W        = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter bit EMIT_RELEASE = 1'b0,
  parameter bit EMIT_MODS    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_data,
  output logic             key_release,
  output logic             mod_shift,
  output logic             mod_ctrl,
  output logic             mod_alt,
  output logic             caps_lock,
  output logic             overflow
);

  prefix_state_e state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d;
  logic          lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic          lalt_q, lalt_d, ralt_q, ralt_d;
  logic          caps_q, caps_d, caps_held_q, caps_held_d;
  logic          overflow_q;

  logic          key_strobe, key_break, key_ext;
  base_key_t     base_key;
  logic [6:0]    code7;
  logic          special;
  logic [7:0]    code8;
  logic [KEY_W-1:0] ev_code;
  logic          push, drop;
  logic          shift_now, ctrl_now;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    key_strobe = 1'b0;
    key_break  = 1'b0;
    key_ext    = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_E0) state_d = ST_EXT;
          else if (scan_code == SC_F0) state_d = ST_BRK;
          else if (scan_code == SC_E1) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_TAIL;
          end else key_strobe = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == SC_F0) state_d = ST_EXT_BRK;
          else if (scan_code != SC_E0) begin
            key_strobe = 1'b1;
            key_ext    = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_strobe = 1'b1;
          key_break  = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_EXT_BRK: begin
          key_strobe = 1'b1;
          key_break  = 1'b1;
          key_ext    = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q <= 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign shift_now = lshift_q | rshift_q;
  assign ctrl_now  = lctrl_q | rctrl_q;

  // Event code uses the modifier state held before this byte takes effect.
  always_comb begin
    base_key    = scan_to_base(scan_code, key_ext);
    code7       = base_key.code;
    special     = 1'b0;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    case (base_key.cls)
      CLS_LETTER: begin
        if (ctrl_now) code7 = base_key.code & 7'h1F;
        else if (shift_now ^ caps_q) code7 = base_key.code & 7'h5F;
      end
      CLS_SHIFT: if (shift_now) code7 = shift_char(base_key.code);
      CLS_SPECIAL, CLS_MOD: special = 1'b1;
      default: ;
    endcase
    if (key_strobe && base_key.cls == CLS_MOD) begin
      case (base_key.code)
        K_LSHIFT: lshift_d = !key_break;
        K_RSHIFT: rshift_d = !key_break;
        K_LCTRL:  lctrl_d  = !key_break;
        K_RCTRL:  rctrl_d  = !key_break;
        K_LALT:   lalt_d   = !key_break;
        K_RALT:   ralt_d   = !key_break;
        K_CAPS: begin
          if (key_break) caps_held_d = 1'b0;
          else begin
            if (!caps_held_q) caps_d = !caps_q;
            caps_held_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign push = key_strobe && (base_key.cls != CLS_NONE) &&
                (!key_break || EMIT_RELEASE) &&
                ((base_key.cls != CLS_MOD) || EMIT_MODS);

  // At KEY_W=7 the special flag bit is simply truncated away.
  assign code8   = {special, code7};
  assign ev_code = code8[KEY_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_q | drop;
    end
  end

  key_event_fifo #(
    .WIDTH(KEY_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i({key_break, ev_code}),
    .pop_i      (key_ready),
    .valid_o    (key_valid),
    .head_o     ({key_release, key_data}),
    .drop_o     (drop)
  );

  assign mod_shift = shift_now;
  assign mod_ctrl  = ctrl_now;
  assign mod_alt   = lalt_q | ralt_q;
  assign caps_lock = caps_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder (KEY_W=8, depth 4, releases emitted,
// modifier events suppressed).
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_data;
  logic       key_release;
  logic       mod_shift, mod_ctrl, mod_alt, caps_lock, overflow;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .KEY_W       (8),
    .FIFO_DEPTH  (4),
    .EMIT_RELEASE(1'b1),
    .EMIT_MODS   (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .key_release(key_release),
    .mod_shift  (mod_shift),
    .mod_ctrl   (mod_ctrl),
    .mod_alt    (mod_alt),
    .caps_lock  (caps_lock),
    .overflow   (overflow)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %s ok value=%0h", name, act);
    end else begin
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic rel, input logic [7:0] data);
    exp_q.push_back({rel, data});
  endtask

  // Called just after a rising edge; the byte is sampled at the next edge.
  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    key_ready = 1'b1;
    while ((exp_q.size() != 0 || key_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size() == 0 && !key_valid), 1);
  endtask

  task automatic monitor_loop();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && key_valid && key_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL event_unexpected got rel=%0b data=%h expected none", key_release, key_data);
        end else begin
          e = exp_q.pop_front();
          if ({key_release, key_data} === e) begin
            n_pass++;
            $display("event rel=%0b data=%h ok", key_release, key_data);
          end else begin
            $display("FAIL event got rel=%0b data=%h expected rel=%0b data=%h",
                     key_release, key_data, e[8], e[7:0]);
          end
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    key_ready  = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_valid", 32'(key_valid), 0);
    check("rst_data", 32'(key_data), 0);
    check("rst_release", 32'(key_release), 0);
    check("rst_shift", 32'(mod_shift), 0);
    check("rst_ctrl", 32'(mod_ctrl), 0);
    check("rst_alt", 32'(mod_alt), 0);
    check("rst_caps", 32'(caps_lock), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Latency and hold while not ready
    expect_ev(1'b0, 8'h61);
    send(8'h1C);
    check("lat_valid", 32'(key_valid), 1);
    check("lat_data", 32'(key_data), 'h61);
    repeat (3) @(posedge clk);
    #1;
    check("hold_data", 32'(key_data), 'h61);
    check("hold_release", 32'(key_release), 0);
    key_ready = 1'b1;

    // Shift + letter
    send(8'h12);
    check("shift_make", 32'(mod_shift), 1);
    expect_ev(1'b0, 8'h41);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    check("shift_break", 32'(mod_shift), 0);

    // CapsLock toggling
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    check("caps_on", 32'(caps_lock), 1);
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    check("caps_off", 32'(caps_lock), 0);
    expect_ev(1'b0, 8'h61);
    send(8'h1C);
    expect_ev(1'b1, 8'h61);
    send(8'hF0);
    send(8'h1C);
    send(8'h58);
    send(8'h58);
    check("caps_repeat", 32'(caps_lock), 1);
    send(8'hF0);
    send(8'h58);
    expect_ev(1'b0, 8'h41);
    send(8'h1C);
    send(8'h12);
    expect_ev(1'b0, 8'h61);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    check("caps_clear", 32'(caps_lock), 0);

    // Extended keys, keypad, fake shift, shifted digit
    expect_ev(1'b0, 8'hA1);
    send(8'hE0);
    send(8'h75);
    expect_ev(1'b0, 8'h38);
    send(8'h75);
    send(8'hE0);
    send(8'h12);
    check("fake_shift", 32'(mod_shift), 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h12);
    send(8'h12);
    expect_ev(1'b0, 8'h21);
    send(8'h16);
    expect_ev(1'b1, 8'h21);
    send(8'hF0);
    send(8'h16);
    send(8'hF0);
    send(8'h12);

    // Pause sequence swallowed
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    check("pause_ctrl", 32'(mod_ctrl), 0);
    expect_ev(1'b0, 8'h31);
    send(8'h16);
    expect_ev(1'b1, 8'h31);
    send(8'hF0);
    send(8'h16);

    // Ctrl-C make and release
    send(8'h14);
    check("ctrl_make", 32'(mod_ctrl), 1);
    expect_ev(1'b0, 8'h03);
    send(8'h21);
    expect_ev(1'b1, 8'h03);
    send(8'hF0);
    send(8'h21);
    send(8'hF0);
    send(8'h14);
    check("ctrl_break", 32'(mod_ctrl), 0);

    // Left/right alt are tracked independently
    send(8'h11);
    send(8'hE0);
    send(8'h11);
    send(8'hF0);
    send(8'h11);
    check("alt_right_held", 32'(mod_alt), 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h11);
    check("alt_released", 32'(mod_alt), 0);

    // Assorted map entries; 07 is unmapped
    expect_ev(1'b0, 8'hA2);
    send(8'hE0);
    send(8'h6B);
    expect_ev(1'b0, 8'h0D);
    send(8'hE0);
    send(8'h5A);
    expect_ev(1'b0, 8'h7F);
    send(8'h71);
    expect_ev(1'b0, 8'h2F);
    send(8'hE0);
    send(8'h4A);
    send(8'h07);
    expect_ev(1'b0, 8'h20);
    send(8'h29);
    expect_ev(1'b0, 8'h1B);
    send(8'h76);
    expect_ev(1'b0, 8'h93);
    send(8'hE0);
    send(8'h71);
    expect_ev(1'b0, 8'h08);
    send(8'h66);
    drain();

    // Reset discards a pending E0 prefix
    send(8'hE0);
    do_reset();
    expect_ev(1'b0, 8'h38);
    send(8'h75);
    drain();

    // Overflow: five makes into a depth-4 FIFO with no consumer
    do_reset();
    key_ready = 1'b0;
    expect_ev(1'b0, 8'h61);
    expect_ev(1'b0, 8'h62);
    expect_ev(1'b0, 8'h63);
    expect_ev(1'b0, 8'h64);
    send(8'h1C);
    send(8'h32);
    send(8'h21);
    send(8'h23);
    check("full_no_overflow", 32'(overflow), 0);
    send(8'h24);
    check("overflow_set", 32'(overflow), 1);
    check("full_head", 32'(key_data), 'h61);
    drain();
    check("overflow_sticky", 32'(overflow), 1);

    // Push and pop together while full
    do_reset();
    check("overflow_reset", 32'(overflow), 0);
    key_ready = 1'b0;
    expect_ev(1'b0, 8'h61);
    expect_ev(1'b0, 8'h62);
    expect_ev(1'b0, 8'h63);
    expect_ev(1'b0, 8'h64);
    expect_ev(1'b0, 8'h65);
    send(8'h1C);
    send(8'h32);
    send(8'h21);
    send(8'h23);
    key_ready = 1'b1;
    send(8'h24);
    check("full_pushpop_overflow", 32'(overflow), 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
